// File: rtl/sram_pkg.sv
// sram_burst_model shared types and helpers.
// State encoding, clog2 and parameter legality checks.
package sram_pkg;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_WAIT = 2'd1,
    SRAM_DONE = 2'd2
  } sram_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(
    input int data_w,
    input int addr_w,
    input int depth,
    input int burst,
    input int wait_cycles
  );
    return (data_w > 0) && (data_w % 8 == 0)
      && is_pow2(depth) && (depth >= 2)
      && (clog2(depth) <= addr_w)
      && is_pow2(burst) && (burst <= 8)
      && (burst <= depth)
      && (wait_cycles >= 0) && (wait_cycles <= 255);
  endfunction

endpackage

// File: rtl/sram_burst_model_if.sv
// Request/ready bus between SRAM controller and model.
// SRAM_ERR exists only when SRAM_PROTO_CHECK_EN is defined.
interface sram_burst_model_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int BURST  = 2
);
  logic                    SRAM_REQ;
  logic                    SRAM_WE_N;
  logic [ADDR_W-1:0]       SRAM_ADDR;
  logic [DATA_W/8-1:0]     SRAM_BE_N;
  logic [DATA_W-1:0]       SRAM_WDATA;
  logic [DATA_W*BURST-1:0] SRAM_RDATA;
  logic                    SRAM_READY;
  logic                    SRAM_BUSY;
`ifdef SRAM_PROTO_CHECK_EN
  logic                    SRAM_ERR;
`endif

  modport master (
    output SRAM_REQ, SRAM_WE_N, SRAM_ADDR,
    output SRAM_BE_N, SRAM_WDATA,
    input  SRAM_RDATA, SRAM_READY, SRAM_BUSY
`ifdef SRAM_PROTO_CHECK_EN
    , input SRAM_ERR
`endif
  );

  modport slave (
    input  SRAM_REQ, SRAM_WE_N, SRAM_ADDR,
    input  SRAM_BE_N, SRAM_WDATA,
    output SRAM_RDATA, SRAM_READY, SRAM_BUSY
`ifdef SRAM_PROTO_CHECK_EN
    , output SRAM_ERR
`endif
  );
endinterface

// File: rtl/sram_bank.sv
// Storage array: byte-enabled write port, aligned burst read.
// Array clear is done through per-word valid bits.
module sram_bank
  import sram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 512,
  parameter  int BURST  = 2,
  localparam int IW     = clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [IW-1:0]           idx,
  input  logic [NB-1:0]           be_n,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W*BURST-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] new_w;
  logic [IW-1:0]     base;

  assign base  = idx & ~IW'(BURST - 1);
  assign old_w = vld[idx] ? mem[idx] : '0;

  always_comb begin
    new_w = old_w;
    for (int b = 0; b < NB; b++)
      if (!be_n[b]) new_w[b*8 +: 8] = wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= new_w;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld   <= '0;
      rdata <= '0;
    end else begin
      if (we) vld[idx] <= 1'b1;
      if (re) begin
        for (int k = 0; k < BURST; k++) begin
          rdata[k*DATA_W +: DATA_W] <=
            vld[base + IW'(k)] ? mem[base + IW'(k)] : '0;
        end
      end
    end
  end

endmodule

// File: rtl/sram_burst_model.sv
// Behavioural SRAM with wait states and burst reads.
// Define SRAM_PROTO_CHECK_EN to add the sticky SRAM_ERR flag.
module sram_burst_model
  import sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 17,
  parameter int DEPTH       = 512,
  parameter int BURST       = 2,
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  sram_burst_model_if.slave bus
);

  localparam int IW = clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam bit LIVE = (WAIT_CYCLES == 0);
  localparam logic [7:0] CNT_INIT =
    LIVE ? 8'd0 : 8'(WAIT_CYCLES - 1);

  if (!cfg_ok(DATA_W, ADDR_W, DEPTH, BURST, WAIT_CYCLES))
  begin : g_bad_cfg
    $error("sram_burst_model: illegal parameters");
  end

  sram_state_e       state;
  logic [7:0]        cnt;
  logic              ready_q;
  logic              we_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_n_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              exec;
  logic              x_we_n;
  logic [ADDR_W-1:0] x_addr;
  logic [NB-1:0]     x_be_n;
  logic [DATA_W-1:0] x_wdata;
  logic [ADDR_W:0]   addr_wide;
  logic [IW-1:0]     idx;

  assign accept = bus.SRAM_REQ && (state != SRAM_WAIT);

  // Zero wait states execute the access off the live bus.
  assign x_we_n  = LIVE ? bus.SRAM_WE_N  : we_n_q;
  assign x_addr  = LIVE ? bus.SRAM_ADDR  : addr_q;
  assign x_be_n  = LIVE ? bus.SRAM_BE_N  : be_n_q;
  assign x_wdata = LIVE ? bus.SRAM_WDATA : wdata_q;
  assign exec    = LIVE ? accept
                 : (state == SRAM_WAIT) && (cnt == '0);

  assign addr_wide = {1'b0, x_addr};
  assign idx = IW'(addr_wide % (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SRAM_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      be_n_q  <= '1;
      wdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        SRAM_WAIT: begin
          if (cnt == '0) begin
            state   <= SRAM_DONE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          if (bus.SRAM_REQ) begin
            we_n_q  <= bus.SRAM_WE_N;
            addr_q  <= bus.SRAM_ADDR;
            be_n_q  <= bus.SRAM_BE_N;
            wdata_q <= bus.SRAM_WDATA;
            if (LIVE) begin
              state   <= SRAM_DONE;
              ready_q <= 1'b1;
            end else begin
              state <= SRAM_WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= SRAM_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.SRAM_READY = ready_q;
  assign bus.SRAM_BUSY  = (state == SRAM_WAIT);

  sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BURST  (BURST)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (exec & ~x_we_n),
    .re    (exec & x_we_n),
    .idx   (idx),
    .be_n  (x_be_n),
    .wdata (x_wdata),
    .rdata (bus.SRAM_RDATA)
  );

`ifdef SRAM_PROTO_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      if (bus.SRAM_REQ && state == SRAM_WAIT) begin
        err_q <= 1'b1;
        $display("%0t sram: REQ while busy, addr=%0h",
                 $time, bus.SRAM_ADDR);
      end
      if (accept && !bus.SRAM_WE_N && &bus.SRAM_BE_N) begin
        err_q <= 1'b1;
        $display("%0t sram: write with no bytes, addr=%0h",
                 $time, bus.SRAM_ADDR);
      end
    end
  end

  assign bus.SRAM_ERR = err_q;
`endif

endmodule

// File: tb/tb_sram_burst_model.sv
// Directed bench for sram_burst_model with a read scoreboard.
// Covers wait-state timing, byte enables, bursts, reset abort, wrap.
module tb_sram_burst_model;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] mdl [512];
  logic [63:0] sb [$];

  sram_burst_model_if #(.DATA_W(32), .ADDR_W(17), .BURST(2)) bus ();
  sram_burst_model_if #(.DATA_W(32), .ADDR_W(17), .BURST(2)) bus0 ();

  sram_burst_model #(
    .DATA_W(32), .ADDR_W(17), .DEPTH(512),
    .BURST(2), .WAIT_CYCLES(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sram_burst_model #(
    .DATA_W(32), .ADDR_W(17), .DEPTH(512),
    .BURST(2), .WAIT_CYCLES(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [16:0] a);
    int base;
    base = int'(a) % 512;
    base = base & ~1;
    return {mdl[base+1], mdl[base]};
  endfunction

  task automatic mdl_write(input logic [16:0] a,
                           input logic [3:0] be_n,
                           input logic [31:0] wd);
    int i;
    i = int'(a) % 512;
    for (int b = 0; b < 4; b++)
      if (!be_n[b]) mdl[i][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 512; i++) mdl[i] = '0;
  endtask

  // One access on the 5-wait DUT; checks latency and busy length.
  task automatic access(input string tag,
                        input logic we_n,
                        input logic [16:0] a,
                        input logic [3:0] be_n,
                        input logic [31:0] wd);
    int lat;
    int busy_n;
    logic [63:0] exp;
    if (we_n) sb.push_back(exp_read(a));
    bus.SRAM_REQ   = 1'b1;
    bus.SRAM_WE_N  = we_n;
    bus.SRAM_ADDR  = a;
    bus.SRAM_BE_N  = be_n;
    bus.SRAM_WDATA = wd;
    @(posedge clk); #1;
    bus.SRAM_REQ = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!bus.SRAM_READY && lat < 40) begin
      if (bus.SRAM_BUSY) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_ready"}, 64'(bus.SRAM_READY), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_busy"}, 64'(busy_n), 64'd5);
    if (!we_n) begin
      mdl_write(a, be_n, wd);
    end else begin
      exp = sb.pop_front();
      check({tag, "_rdata"}, bus.SRAM_RDATA, exp);
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(bus.SRAM_READY), 64'd0);
  endtask

  task automatic access0(input string tag,
                         input logic we_n,
                         input logic [16:0] a,
                         input logic [3:0] be_n,
                         input logic [31:0] wd);
    logic [63:0] exp;
    if (we_n) sb.push_back(exp_read(a));
    bus0.SRAM_REQ   = 1'b1;
    bus0.SRAM_WE_N  = we_n;
    bus0.SRAM_ADDR  = a;
    bus0.SRAM_BE_N  = be_n;
    bus0.SRAM_WDATA = wd;
    @(posedge clk); #1;
    bus0.SRAM_REQ = 1'b0;
    check({tag, "_ready"}, 64'(bus0.SRAM_READY), 64'd1);
    if (!we_n) begin
      mdl_write(a, be_n, wd);
    end else begin
      exp = sb.pop_front();
      check({tag, "_rdata"}, bus0.SRAM_RDATA, exp);
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(bus0.SRAM_READY), 64'd0);
  endtask

  initial begin
    int pulses;
    int last;
    int rdy_n;
    errors = 0;
    checks = 0;
    mdl_clear();
    bus.SRAM_REQ    = 1'b0;
    bus.SRAM_WE_N   = 1'b1;
    bus.SRAM_ADDR   = '0;
    bus.SRAM_BE_N   = '1;
    bus.SRAM_WDATA  = '0;
    bus0.SRAM_REQ   = 1'b0;
    bus0.SRAM_WE_N  = 1'b1;
    bus0.SRAM_ADDR  = '0;
    bus0.SRAM_BE_N  = '1;
    bus0.SRAM_WDATA = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_busy", 64'(bus.SRAM_BUSY), 64'd0);
    check("rst_ready", 64'(bus.SRAM_READY), 64'd0);
    check("rst_rdata", bus.SRAM_RDATA, 64'd0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    access("rd10", 1'b1, 17'h10, 4'hF, 32'h0);

    access("wr4a", 1'b0, 17'h4, 4'b0000, 32'hDEADBEEF);
    access("wr4b", 1'b0, 17'h4, 4'b1101, 32'h0000AA00);
    access("rd4", 1'b1, 17'h4, 4'hF, 32'h0);
    check("rd4_const", bus.SRAM_RDATA, 64'h00000000_DEADAAEF);

    access("wr2", 1'b0, 17'h2, 4'b0000, 32'h11);
    access("wr3", 1'b0, 17'h3, 4'b0000, 32'h22);
    access("rd3", 1'b1, 17'h3, 4'hF, 32'h0);
    check("rd3_const", bus.SRAM_RDATA, 64'h00000022_00000011);

    // REQ held high: one completion every WAIT_CYCLES+1 cycles.
    bus.SRAM_REQ  = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_ADDR = 17'h4;
    @(posedge clk); #1;
    pulses = 0;
    last = 0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (bus.SRAM_READY) begin
        pulses++;
        if (pulses == 1) check("hold_first", 64'(i), 64'd5);
        else check("hold_gap", 64'(i - last), 64'd6);
        last = i;
        check("hold_rdata", bus.SRAM_RDATA, exp_read(17'h4));
      end
    end
    bus.SRAM_REQ = 1'b0;
    check("hold_pulses", 64'(pulses), 64'd3);
`ifdef SRAM_PROTO_CHECK_EN
    check("hold_err", 64'(bus.SRAM_ERR), 64'd1);
`endif
    @(posedge clk); #1;
    check("hold_idle", 64'(bus.SRAM_READY), 64'd0);

    // Reset lands while a write is in its wait states.
    bus.SRAM_REQ   = 1'b1;
    bus.SRAM_WE_N  = 1'b0;
    bus.SRAM_ADDR  = 17'h7;
    bus.SRAM_BE_N  = 4'b0000;
    bus.SRAM_WDATA = 32'h55;
    @(posedge clk); #1;
    bus.SRAM_REQ = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_pre", 64'(bus.SRAM_BUSY), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus.SRAM_BUSY), 64'd0);
    check("abort_ready", 64'(bus.SRAM_READY), 64'd0);
    check("abort_rdata", bus.SRAM_RDATA, 64'd0);
`ifdef SRAM_PROTO_CHECK_EN
    check("abort_err", 64'(bus.SRAM_ERR), 64'd0);
`endif
    mdl_clear();
    @(posedge clk); #3;
    rst = 1'b1;
    rdy_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.SRAM_READY) rdy_n++;
    end
    check("abort_no_ready", 64'(rdy_n), 64'd0);
    access("rd7", 1'b1, 17'h7, 4'hF, 32'h0);
    check("rd7_const", bus.SRAM_RDATA, 64'd0);
    access("rd4_clr", 1'b1, 17'h4, 4'hF, 32'h0);

    // Zero-wait instance: next-cycle READY and index wrap.
    access0("z_wr5", 1'b0, 17'h5, 4'b0000, 32'h12345678);
    access0("z_rd205", 1'b1, 17'h205, 4'hF, 32'h0);
    check("z_rd205_const", bus0.SRAM_RDATA,
          64'h12345678_00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_burst_model.md
# sram_burst_model

Parametrised behavioural SRAM model with a request/ready handshake, programmable wait states, byte-enabled single-word writes and aligned multi-word burst reads. It succeeds the fixed 32-bit/512-word, two-word-read, zero-wait model. It sits between the memory-stage SRAM controller and the testbench, and lets controller timing be exercised against realistic access latency.

## Interface
- DATA_W, 32, word width in bits; multiple of 8.
- ADDR_W, 17, word-address width.
- DEPTH, 512, number of stored words; power of 2, ≤ 2^ADDR_W.
- BURST, 2, words returned per read; power of 2, 1..8.
- WAIT_CYCLES, 5, wait states per access, 0..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- SRAM_REQ  in  1  access request; sampled only when SRAM_BUSY = 0.
- SRAM_WE_N  in  1  0 = write, 1 = read; latched with the request.
- SRAM_ADDR  in  ADDR_W  word address; latched with the request.
- SRAM_BE_N  in  DATA_W/8  active-low byte enables for writes.
- SRAM_WDATA  in  DATA_W  write data; latched with the request.
- SRAM_RDATA  out  DATA_W*BURST  burst read data, word 0 in the LSBs.
- SRAM_READY  out  1  one-cycle completion pulse.
- SRAM_BUSY  out  1  high while an access is in wait states.

## Operation
- States are IDLE, WAIT and DONE. SRAM_BUSY = (state == WAIT).
- Accept: REQ = 1 in IDLE or DONE latches WE_N, ADDR, BE_N and WDATA.
  - If WAIT_CYCLES = 0, the next state is DONE and the access executes at the same edge.
  - Otherwise the next state is WAIT and cnt is loaded with WAIT_CYCLES-1.
- WAIT: cnt = 0 → DONE, and the access executes at that edge. Otherwise cnt decrements. REQ is ignored in WAIT and is not queued.
- DONE: READY = 1 for this cycle only. Next state is WAIT or DONE if REQ = 1 (new accept), else IDLE.
- Index: idx = ADDR mod DEPTH, i.e. the low log2(DEPTH) bits. Out-of-range addresses wrap silently.
- Write: for each byte b with BE_N[b] = 0, mem[idx] byte b ← WDATA byte b. Other bytes are unchanged. RDATA is unchanged.
- Read: base = idx with the low log2(BURST) bits cleared. RDATA word k ← mem[base+k] for k = 0..BURST-1. RDATA holds until the next read executes.
- A read that executes after a write to the same word returns the new data.

## Timing
- Reset (rst = 0, asynchronous):
  - state IDLE, cnt 0, READY 0, BUSY 0, RDATA 0.
  - All DEPTH words cleared to 0.
  - Any in-flight access is aborted; its write never lands.
- Latency: REQ sampled at edge E0 → READY high in the cycle following edge E0+WAIT_CYCLES.
- Throughput: back-to-back accesses complete every WAIT_CYCLES+1 cycles, because REQ is accepted while in DONE.
- RDATA is valid from the cycle READY rises. Write data lands at the same edge READY rises.
- Release of rst mid-cycle gives no READY until a new REQ is accepted.

## Configuration
- SRAM_PROTO_CHECK_EN defined:
  - Adds output SRAM_ERR (1 bit), reset 0.
  - SRAM_ERR is sticky-set at any edge where REQ = 1 while BUSY = 1, or where a write is accepted with all BE_N = 1.
  - Each set event emits a simulation $display with time and address.
  - SRAM_ERR clears only on reset.
- Undefined: the port is absent, ignored requests are silent, and an all-disabled write is a no-op.

## Structure
- sram_pkg holds:
  - state encoding localparams SRAM_IDLE, SRAM_WAIT, SRAM_DONE;
  - a clog2 function;
  - parameter legality checks (DEPTH and BURST powers of 2, DATA_W % 8 == 0).
- One sub-module, sram_bank: the storage array with async clear, byte-enabled write port and BURST-wide aligned read port.
- The FSM, wait counter and request latches stay in the top level.

## Test plan
- Reset, then read addr 0x10 with WAIT_CYCLES = 5 → READY exactly 6 edges after REQ, RDATA = 64'h0, BUSY high for 5 cycles.
- Write 0xDEADBEEF to addr 4 (BE_N = 0), then write 0x0000AA00 to addr 4 with BE_N = 4'b1101 → read addr 4 gives word 0 = 0xDEADBEEF, except byte 1 = 0xAA (0xDEADAAEF). Word 1 = mem[5] = 0.
- Write 0x11 to addr 2 and 0x22 to addr 3, then read addr 3 with BURST = 2 → RDATA = {32'h22, 32'h11} (aligned base 2).
- Hold REQ high continuously for reads → READY pulses every 6 cycles. REQ held during WAIT causes no extra access. With SRAM_PROTO_CHECK_EN, SRAM_ERR = 1.
- Assert rst low during WAIT of a write of 0x55 to addr 7 → READY never pulses, and a later read of addr 7 returns 0.
- WAIT_CYCLES = 0 and DEPTH = 512: read addr 0x205 → READY on the next cycle, and the data is from idx 5 (wrap).
